serial_frame_tx_1101: RTL and testbench

- Serial transmitter for the 1101-marker serial link; the counterpart of the Moore 1101 sequence detector on the receive end.
- On a start request it latches a parallel payload and emits a frame on the one-bit serial line `x`: preamble 1101, then the payload MSB first, then an optional parity bit.
- The line idles at 0 between frames.
- Sits between a parallel producer and the serial wire.

---
 rtl/serial_frame_tx_1101.sv | 111 +++++++++++
 tb/tb_serial_frame_tx_1101.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx_1101.sv
// Serial frame transmitter: 1101 preamble, then payload MSB first, optional even parity bit.
// Define SERIAL_FRAME_TX_PARITY_EN to compile in the trailing parity bit (PAR state).
module serial_frame_tx_1101 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              x,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | line at 0, waiting for start
    // PRE   | sending the 1101 preamble, one bit per cycle
    // DATA  | sending the captured payload MSB first
    // PAR   | sending the even-parity bit (parity build only)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       PREAMBLE = 4'b1101;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [1:0]        pre_idx;
    logic              done_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              par_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            pre_idx <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            // done marks the first idle cycle after the last frame bit
            done_q <= (state != IDLE) && (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= data;
                        pre_idx <= '0;
                        bit_cnt <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par_q   <= ^data;
`endif
                    end
                end
                PRE:  pre_idx <= pre_idx + 2'd1;
                DATA: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = PRE;
            PRE:  if (pre_idx == 2'd3) state_next = DATA;
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_next = PAR;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PAR:  state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        x    = 1'b0;
        busy = (state != IDLE);
        done = done_q;
        case (state)
            PRE:  x = PREAMBLE[2'd3 - pre_idx];
            DATA: x = shreg[DATA_W-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PAR:  x = par_q;
`endif
            default: x = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx_1101.sv
// Scoreboard bench for serial_frame_tx_1101: a frame-level model queues expected frames,
// a negedge monitor checks every line cycle against them.
module tb_serial_frame_tx_1101;

    localparam int DATA_W = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int FW = DATA_W + 5;
`else
    localparam int FW = DATA_W + 4;
`endif

    typedef struct {
        int          acc_edge;
        logic [FW-1:0] bits;
    } frame_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              x;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int next_free = 0;
    frame_t q[$];

    serial_frame_tx_1101 #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .x(x), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] make_frame(input logic [DATA_W-1:0] d);
        logic [FW-1:0] f;
        int ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        f = {4'b1101, d, logic'(ones % 2)};
`else
        f = {4'b1101, d};
`endif
        return f;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, act, exp);
        end
    endtask

    // Frame-level reference: a start seen while the link is free launches a frame.
    always @(posedge clk) begin
        edge_cnt++;
        if (!reset) begin
            q.delete();
            next_free = 0;
        end else if (start && edge_cnt >= next_free) begin
            q.push_back('{acc_edge: edge_cnt, bits: make_frame(data)});
            next_free = edge_cnt + FW + 1;
        end
    end

    logic in_frame = 1'b0;
    logic expect_done = 1'b0;
    int pos = 0;
    frame_t cur;

    always @(negedge clk) begin
        if (!reset) begin
            check("reset_x", x, 1'b0);
            check("reset_busy", busy, 1'b0);
            check("reset_done", done, 1'b0);
            in_frame = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (!in_frame && busy) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame at edge %0d: busy=1, expected idle", edge_cnt);
                    cur.bits = '0;
                end else begin
                    cur = q.pop_front();
                    tests++;
                    if (cur.acc_edge != edge_cnt) begin
                        fails++;
                        $display("FAIL frame_start edge %0d, expected accept edge %0d", edge_cnt, cur.acc_edge);
                    end
                end
                in_frame = 1'b1;
                pos = 0;
            end else if (!in_frame && q.size() > 0 && q[0].acc_edge < edge_cnt) begin
                tests++; fails++;
                $display("FAIL missing_frame at edge %0d: accepted at edge %0d, busy=%b", edge_cnt, q[0].acc_edge, busy);
                void'(q.pop_front());
            end
            if (in_frame) begin
                check("frame_busy", busy, 1'b1);
                check("frame_x", x, cur.bits[FW-1-pos]);
                check("frame_done", done, 1'b0);
                pos++;
                if (pos == FW) begin
                    in_frame = 1'b0;
                    expect_done = 1'b1;
                end
            end else begin
                check("idle_busy", busy, 1'b0);
                check("idle_x", x, 1'b0);
                check("idle_done", done, expect_done);
                expect_done = 1'b0;
            end
        end
    end

    task automatic pulse(input logic [DATA_W-1:0] d);
        @(negedge clk);
        start = 1'b1;
        data = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset held with a pending request
        start = 1'b1;
        data = 8'hFF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        idle(4);

        // single frame, then a start during the busy window is ignored
        pulse(8'hA5);
        idle(3);
        pulse(8'h3C);
        idle(FW + 4);

        pulse(8'h07);
        idle(FW + 3);
        pulse(8'hA5);
        idle(FW + 3);

        // start held high: back-to-back frames with one idle gap
        @(negedge clk);
        start = 1'b1;
        data = 8'hF0;
        repeat (3 * (FW + 1) + 2) @(negedge clk);
        start = 1'b0;
        idle(FW + 3);

        // reset asserted during payload bit 3
        pulse(8'hA5);
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("async_reset_x", x, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        pulse(8'h81);
        idle(FW + 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            data = DATA_W'($urandom);
        end
        start = 1'b0;
        idle(FW + 4);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: %0d frames left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
